// File: rtl/mem_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sb
// Brief    : Memory stage with an in-order store buffer, store-to-load
//            forwarding and a single-outstanding data-memory port.
// Revision : 1.0
// ============================================================================
module mem_stage_sb #(
    parameter int SB_DEPTH = 4,
    parameter int MAP_W    = 6
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [5:0]                 in_op,
    input  logic [31:0]                in_addr,
    input  logic [31:0]                in_wdata,
    input  logic                       in_regwrite,
    input  logic [4:0]                 in_wreg,
    input  logic [MAP_W-1:0]           in_map,
    output logic                       out_valid,
    output logic                       out_regwrite,
    output logic [4:0]                 out_wreg,
    output logic [31:0]                out_wdata,
    output logic [MAP_W-1:0]           out_map,
    output logic                       dm_req,
    output logic                       dm_we,
    output logic [31:0]                dm_addr,
    output logic [31:0]                dm_wdata,
    output logic [3:0]                 dm_be,
    input  logic                       dm_ack,
    input  logic [31:0]                dm_rdata,
    output logic [$clog2(SB_DEPTH):0]  sb_count,
    output logic                       sb_full,
    output logic                       sb_empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [5:0] c_OP_LW  = 6'b111101;
    localparam logic [5:0] c_OP_LB  = 6'b100001;
    localparam logic [5:0] c_OP_LBU = 6'b101010;
    localparam logic [5:0] c_OP_LH  = 6'b101011;
    localparam logic [5:0] c_OP_LHU = 6'b101100;
    localparam logic [5:0] c_OP_SW  = 6'b110001;
    localparam logic [5:0] c_OP_SB  = 6'b101111;
    localparam logic [5:0] c_OP_SH  = 6'b110000;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        DRAIN_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [29:0]      r_sb_addr [SB_DEPTH];
    logic [3:0]       r_sb_be   [SB_DEPTH];
    logic [31:0]      r_sb_data [SB_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;

    logic [5:0]       r_ld_op;
    logic [1:0]       r_ld_off;
    logic             r_ld_regwrite;
    logic [4:0]       r_ld_wreg;
    logic [MAP_W-1:0] r_ld_map;

    logic             r_out_valid;
    logic             r_out_regwrite;
    logic [4:0]       r_out_wreg;
    logic [31:0]      r_out_wdata;
    logic [MAP_W-1:0] r_out_map;

    logic             r_dm_req;
    logic             r_dm_we;
    logic [31:0]      r_dm_addr;
    logic [31:0]      r_dm_wdata;
    logic [3:0]       r_dm_be;

    logic        w_is_load, w_is_store;
    logic [1:0]  w_off;
    logic [3:0]  w_need;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic        w_hit;
    logic [3:0]  w_hit_be;
    logic [31:0] w_hit_data;
    logic        w_fwd_ok, w_stall, w_ld_mem;
    logic        w_full, w_empty;
    logic        w_in_ready, w_accept, w_drain_go;
    logic        w_ack, w_enq, w_pop;

    // Big-endian extraction: offset 0 is the most significant byte.
    function automatic logic [31:0] f_load_fmt(input logic [5:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (op)
            c_OP_LB:  r = {{24{b[7]}}, b};
            c_OP_LBU: r = {24'd0, b};
            c_OP_LH:  r = {{16{h[15]}}, h};
            c_OP_LHU: r = {16'd0, h};
            default:  r = word;
        endcase
        return r;
    endfunction

    assign w_is_load  = (in_op == c_OP_LW) || (in_op == c_OP_LB) || (in_op == c_OP_LBU) ||
                        (in_op == c_OP_LH) || (in_op == c_OP_LHU);
    assign w_is_store = (in_op == c_OP_SW) || (in_op == c_OP_SB) || (in_op == c_OP_SH);
    assign w_off      = in_addr[1:0];

    always_comb begin
        w_need    = 4'b0000;
        w_st_be   = 4'b0000;
        w_st_data = 32'd0;
        case (in_op)
            c_OP_LW:                    w_need = 4'b1111;
            c_OP_LB, c_OP_LBU:          w_need = 4'b1000 >> w_off;
            c_OP_LH, c_OP_LHU:          w_need = w_off[1] ? 4'b0011 : 4'b1100;
            default:                    w_need = 4'b0000;
        endcase
        case (in_op)
            c_OP_SW: begin
                w_st_be   = 4'b1111;
                w_st_data = in_wdata;
            end
            c_OP_SB: begin
                w_st_be   = 4'b1000 >> w_off;
                w_st_data = {24'd0, in_wdata[7:0]} << {~w_off, 3'b000};
            end
            c_OP_SH: begin
                w_st_be   = w_off[1] ? 4'b0011 : 4'b1100;
                w_st_data = w_off[1] ? {16'd0, in_wdata[15:0]} : {in_wdata[15:0], 16'd0};
            end
            default: begin
                w_st_be   = 4'b0000;
                w_st_data = 32'd0;
            end
        endcase
    end

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        w_hit      = 1'b0;
        w_hit_be   = 4'b0000;
        w_hit_data = 32'd0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = r_rptr + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_sb_addr[idx] == in_addr[31:2])) begin
                w_hit      = 1'b1;
                w_hit_be   = r_sb_be[idx];
                w_hit_data = r_sb_data[idx];
            end
        end
    end

    assign w_fwd_ok = w_hit && ((w_hit_be & w_need) == w_need);
    assign w_stall  = w_is_load && w_hit && !w_fwd_ok;
    assign w_ld_mem = w_is_load && !w_hit;
    assign w_full   = (r_count == CNT_W'(SB_DEPTH));
    assign w_empty  = (r_count == '0);

    // A memory-bound load is held off while full so the drain can make room.
    assign w_in_ready = (r_state == IDLE) && !RESET && !(w_is_store && w_full) &&
                        !w_stall && !(w_ld_mem && w_full);
    assign w_accept   = in_valid && w_in_ready;
    assign w_drain_go = (r_state == IDLE) && !w_empty && (!in_valid || !w_in_ready || w_full);
    assign w_ack      = dm_ack && r_dm_req;
    assign w_enq      = w_accept && w_is_store;
    assign w_pop      = w_ack && (r_state == DRAIN_WAIT);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_ld_mem)
                    w_state_nxt = LOAD_WAIT;
                else if (w_drain_go)
                    w_state_nxt = DRAIN_WAIT;
            end
            LOAD_WAIT, DRAIN_WAIT: begin
                if (w_ack)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_sb_addr[r_wptr] <= in_addr[31:2];
            r_sb_be[r_wptr]   <= w_st_be;
            r_sb_data[r_wptr] <= w_st_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ld_op       <= 6'd0;
            r_ld_off      <= 2'd0;
            r_ld_regwrite <= 1'b0;
            r_ld_wreg     <= 5'd0;
            r_ld_map      <= '0;
        end else if (w_accept && w_ld_mem) begin
            r_ld_op       <= in_op;
            r_ld_off      <= w_off;
            r_ld_regwrite <= in_regwrite;
            r_ld_wreg     <= in_wreg;
            r_ld_map      <= in_map;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_out_valid    <= 1'b0;
            r_out_regwrite <= 1'b0;
            r_out_wreg     <= 5'd0;
            r_out_wdata    <= 32'd0;
            r_out_map      <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_ack && (r_state == LOAD_WAIT)) begin
                r_out_valid    <= 1'b1;
                r_out_regwrite <= r_ld_regwrite;
                r_out_wreg     <= r_ld_wreg;
                r_out_wdata    <= f_load_fmt(r_ld_op, r_ld_off, dm_rdata);
                r_out_map      <= r_ld_map;
            end else if (w_accept && !w_ld_mem) begin
                r_out_valid    <= 1'b1;
                r_out_regwrite <= w_is_store ? 1'b0 : in_regwrite;
                r_out_wreg     <= in_wreg;
                r_out_wdata    <= w_is_load ? f_load_fmt(in_op, w_off, w_hit_data) : in_addr;
                r_out_map      <= in_map;
            end
        end
    end

    // dm outputs are registered on entry to a WAIT state, so they hold until ack.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= 32'd0;
            r_dm_wdata <= 32'd0;
            r_dm_be    <= 4'b0000;
        end else if (w_ack) begin
            r_dm_req <= 1'b0;
            r_dm_we  <= 1'b0;
        end else if ((r_state == IDLE) && (w_state_nxt == LOAD_WAIT)) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= {in_addr[31:2], 2'b00};
            r_dm_wdata <= 32'd0;
            r_dm_be    <= w_need;
        end else if ((r_state == IDLE) && (w_state_nxt == DRAIN_WAIT)) begin
            r_dm_req   <= 1'b1;
            r_dm_we    <= 1'b1;
            r_dm_addr  <= {r_sb_addr[r_rptr], 2'b00};
            r_dm_wdata <= r_sb_data[r_rptr];
            r_dm_be    <= r_sb_be[r_rptr];
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = r_out_valid;
    assign out_regwrite = r_out_regwrite;
    assign out_wreg     = r_out_wreg;
    assign out_wdata    = r_out_wdata;
    assign out_map      = r_out_map;
    assign dm_req       = r_dm_req;
    assign dm_we        = r_dm_we;
    assign dm_addr      = r_dm_addr;
    assign dm_wdata     = r_dm_wdata;
    assign dm_be        = r_dm_be;
    assign sb_count     = r_count;
    assign sb_full      = w_full;
    assign sb_empty     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_sb
// Brief    : Directed self-checking bench for mem_stage_sb.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_sb;

    localparam logic [5:0] c_OP_LW  = 6'b111101;
    localparam logic [5:0] c_OP_LB  = 6'b100001;
    localparam logic [5:0] c_OP_LBU = 6'b101010;
    localparam logic [5:0] c_OP_LH  = 6'b101011;
    localparam logic [5:0] c_OP_SW  = 6'b110001;
    localparam logic [5:0] c_OP_SB  = 6'b101111;
    localparam logic [5:0] c_OP_ALU = 6'b100000;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_regwrite;
    logic [4:0]  in_wreg;
    logic [5:0]  in_map;
    logic        out_valid;
    logic        out_regwrite;
    logic [4:0]  out_wreg;
    logic [31:0] out_wdata;
    logic [5:0]  out_map;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic [2:0]  sb_count;
    logic        sb_full;
    logic        sb_empty;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage_sb #(.SB_DEPTH(4), .MAP_W(6)) u_dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_regwrite  (in_regwrite),
        .in_wreg      (in_wreg),
        .in_map       (in_map),
        .out_valid    (out_valid),
        .out_regwrite (out_regwrite),
        .out_wreg     (out_wreg),
        .out_wdata    (out_wdata),
        .out_map      (out_map),
        .dm_req       (dm_req),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_be        (dm_be),
        .dm_ack       (dm_ack),
        .dm_rdata     (dm_rdata),
        .sb_count     (sb_count),
        .sb_full      (sb_full),
        .sb_empty     (sb_empty)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic drive(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic rw, input logic [4:0] wr, input logic [5:0] mp);
        in_valid    = 1'b1;
        in_op       = op;
        in_addr     = addr;
        in_wdata    = wd;
        in_regwrite = rw;
        in_wreg     = wr;
        in_map      = mp;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (dm_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, {31'd0, dm_req}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; in_valid = 1'b0; in_op = 6'd0; in_addr = 32'd0; in_wdata = 32'd0;
        in_regwrite = 1'b0; in_wreg = 5'd0; in_map = 6'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
        repeat (2) step();
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_count", {29'd0, sb_count}, 32'd0);
        chk("rst_empty", {31'd0, sb_empty}, 32'd1);
        chk("rst_full", {31'd0, sb_full}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
        step();
        RESET = 1'b0;

        // ALU pass-through
        drive(c_OP_ALU, 32'hDEADBEEF, 32'd0, 1'b1, 5'd7, 6'd5);
        #1 chk("alu_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("alu_valid", {31'd0, out_valid}, 32'd1);
        chk("alu_wdata", out_wdata, 32'hDEADBEEF);
        chk("alu_map", {26'd0, out_map}, 32'd5);
        chk("alu_wreg", {27'd0, out_wreg}, 32'd7);
        chk("alu_regwrite", {31'd0, out_regwrite}, 32'd1);
        step();
        #1 chk("alu_valid_1cyc", {31'd0, out_valid}, 32'd0);

        // SB then forwarded LBU
        step();
        drive(c_OP_SB, 32'h00001001, 32'h000000AB, 1'b0, 5'd3, 6'd1);
        step();
        #1;
        chk("sb_valid", {31'd0, out_valid}, 32'd1);
        chk("sb_regwrite", {31'd0, out_regwrite}, 32'd0);
        chk("sb_count1", {29'd0, sb_count}, 32'd1);
        drive(c_OP_LBU, 32'h00001001, 32'd0, 1'b1, 5'd4, 6'd2);
        #1 chk("lbu_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1;
        chk("lbu_valid", {31'd0, out_valid}, 32'd1);
        chk("lbu_fwd", out_wdata, 32'h000000AB);
        chk("lbu_map", {26'd0, out_map}, 32'd2);
        chk("lbu_no_req", {31'd0, dm_req}, 32'd0);
        wait_req("sb_drain_req");
        chk("sb_drain_we", {31'd0, dm_we}, 32'd1);
        chk("sb_drain_be", {28'd0, dm_be}, 32'h4);
        chk("sb_drain_data", dm_wdata, 32'h00AB0000);
        chk("sb_drain_addr", dm_addr, 32'h00001000);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1 chk("sb_drain_empty", {31'd0, sb_empty}, 32'd1);

        // SB then LW to same word: partial overlap stall
        step();
        drive(c_OP_SB, 32'h00002000, 32'h00000055, 1'b0, 5'd0, 6'd0);
        step();
        drive(c_OP_LW, 32'h00002000, 32'd0, 1'b1, 5'd9, 6'd3);
        #1 chk("lw_stall0", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        chk("lw_stall1", {31'd0, in_ready}, 32'd0);
        chk("ov_drain_req", {31'd0, dm_req}, 32'd1);
        chk("ov_drain_we", {31'd0, dm_we}, 32'd1);
        chk("ov_drain_be", {28'd0, dm_be}, 32'h8);
        chk("ov_drain_data", dm_wdata, 32'h55000000);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("lw_ready", {31'd0, in_ready}, 32'd1);
        chk("ov_count0", {29'd0, sb_count}, 32'd0);
        step();
        in_valid = 1'b0;
        #1;
        chk("lw_req", {31'd0, dm_req}, 32'd1);
        chk("lw_we", {31'd0, dm_we}, 32'd0);
        chk("lw_addr", dm_addr, 32'h00002000);
        dm_rdata = 32'hCAFEF00D;
        dm_ack   = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("lw_valid", {31'd0, out_valid}, 32'd1);
        chk("lw_data", out_wdata, 32'hCAFEF00D);
        chk("lw_wreg", {27'd0, out_wreg}, 32'd9);
        chk("lw_req_done", {31'd0, dm_req}, 32'd0);

        // LH with 3-cycle ack delay
        step();
        drive(c_OP_LH, 32'h00003002, 32'd0, 1'b1, 5'd10, 6'd4);
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("lh_req", {31'd0, dm_req}, 32'd1);
            chk("lh_addr", dm_addr, 32'h00003000);
            chk("lh_no_valid", {31'd0, out_valid}, 32'd0);
            if (k < 2) step();
        end
        dm_rdata = 32'h1234F00D;
        dm_ack   = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("lh_valid", {31'd0, out_valid}, 32'd1);
        chk("lh_data", out_wdata, 32'hFFFFF00D);
        step();
        #1 chk("lh_valid_1cyc", {31'd0, out_valid}, 32'd0);

        // LB sign-extension through forwarding
        drive(c_OP_SB, 32'h00006003, 32'h00000080, 1'b0, 5'd0, 6'd0);
        step();
        drive(c_OP_LB, 32'h00006003, 32'd0, 1'b1, 5'd1, 6'd0);
        step();
        in_valid = 1'b0;
        #1 chk("lb_fwd", out_wdata, 32'hFFFFFF80);
        wait_req("lb_drain_req");
        chk("lb_drain_be", {28'd0, dm_be}, 32'h1);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;

        // Fill the buffer, stall, one ack, refill across the wrap
        step();
        for (int k = 0; k < 4; k++) begin
            drive(c_OP_SW, 32'h00004000 + 32'(4 * k), 32'(k + 1), 1'b0, 5'd0, 6'd0);
            #1 chk("fill_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        drive(c_OP_SW, 32'h00004010, 32'd5, 1'b0, 5'd0, 6'd0);
        #1;
        chk("full_flag", {31'd0, sb_full}, 32'd1);
        chk("full_count", {29'd0, sb_count}, 32'd4);
        chk("full_stall", {31'd0, in_ready}, 32'd0);
        step();
        #1;
        chk("full_drain_req", {31'd0, dm_req}, 32'd1);
        chk("full_drain_addr", dm_addr, 32'h00004000);
        chk("full_stall2", {31'd0, in_ready}, 32'd0);
        step();
        #1 chk("full_hold", {31'd0, sb_full}, 32'd1);
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("ack_count", {29'd0, sb_count}, 32'd3);
        chk("ack_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        #1 chk("refill_count", {29'd0, sb_count}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            wait_req("fifo_req");
            chk("fifo_addr", dm_addr, 32'h00004004 + 32'(4 * k));
            chk("fifo_data", dm_wdata, 32'(k + 2));
            dm_ack = 1'b1;
            step();
            dm_ack = 1'b0;
        end
        #1 chk("fifo_empty", {31'd0, sb_empty}, 32'd1);

        // Reset during DRAIN_WAIT
        step();
        drive(c_OP_SW, 32'h00005000, 32'h11111111, 1'b0, 5'd0, 6'd0);
        step();
        drive(c_OP_SW, 32'h00005004, 32'h22222222, 1'b0, 5'd0, 6'd0);
        step();
        in_valid = 1'b0;
        wait_req("rd_req");
        chk("rd_count2", {29'd0, sb_count}, 32'd2);
        RESET = 1'b1;
        step();
        #1;
        chk("rd_count0", {29'd0, sb_count}, 32'd0);
        chk("rd_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rd_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rd_in_ready", {31'd0, in_ready}, 32'd0);
        RESET  = 1'b0;
        dm_ack = 1'b1;
        step();
        dm_ack = 1'b0;
        #1;
        chk("late_count", {29'd0, sb_count}, 32'd0);
        chk("late_dm_req", {31'd0, dm_req}, 32'd0);
        chk("late_out_valid", {31'd0, out_valid}, 32'd0);
        chk("late_ready", {31'd0, in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_sb.md
MEM_STAGE_SB -- requirements
Module: mem_stage_sb

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4: store-buffer entries; power of 2, range 2..16.
REQ-002 SHALL have parameter MAP_W, default 6: width of the physical-register broadcast map.
REQ-003 SHALL have ports: CLK in 1 (one clock, all logic on rising edge); RESET in 1 (synchronous, active-high).
REQ-004 SHALL have upstream ports: in_valid in 1; in_ready out 1; in_op in 6 (ALU-control code); in_addr in 32; in_wdata in 32 (store data); in_regwrite in 1; in_wreg in 5; in_map in MAP_W.
REQ-005 SHALL have writeback ports: out_valid out 1; out_regwrite out 1; out_wreg out 5; out_wdata out 32; out_map out MAP_W.
REQ-006 SHALL have data-memory ports: dm_req out 1; dm_we out 1; dm_addr out 32 (word-aligned); dm_wdata out 32; dm_be out 4 (bit3 = bits[31:24]); dm_ack in 1; dm_rdata in 32.
REQ-007 SHALL have status ports: sb_count out $clog2(SB_DEPTH)+1; sb_full out 1; sb_empty out 1.

Function
REQ-008 SHALL decode in_op as follows: LW 111101; LB 100001; LBU 101010; LH 101011; LHU 101100; SW 110001; SB 101111; SH 110000. Any other code is a pass-through.
REQ-009 SHALL use big-endian byte lanes: offset 0 maps to bits[31:24]. Store data SHALL be taken from low bytes of in_wdata and placed on the lanes selected by in_addr[1:0].
REQ-010 SHALL complete a pass-through op accepted at edge N with out_valid at N+1 and out_wdata = in_addr (the ALU result).
REQ-011 SHALL enqueue an accepted store into the buffer as {addr[31:2], be, lane-aligned data}. The store SHALL produce out_valid at N+1 with out_regwrite=0.
REQ-012 SHALL sign-extend LB/LH results and zero-extend LBU/LHU results. LH/LHU SHALL use offsets 0 and 2 only; odd offsets are undefined.
REQ-013 SHALL match a load against buffer entries with the same addr[31:2]. If the youngest matching entry's be covers all bytes the load needs, the load SHALL be forwarded from that entry with out_valid at N+1.
REQ-014 SHALL deassert in_ready while the presented load matches any entry that does not satisfy REQ-013 (partial overlap), until those entries have drained.
REQ-015 SHALL send a load with no match to memory. It SHALL enter LOAD_WAIT with dm_req=1, dm_we=0, and hold dm_addr. At the cycle dm_ack=1 it SHALL capture dm_rdata, and out_valid SHALL be 1 at the next edge.
REQ-016 SHALL drain the buffer in FIFO order. From IDLE with the buffer non-empty and no load presented, it SHALL enter DRAIN_WAIT with dm_req=1, dm_we=1, and the head's addr/be/data. The head SHALL pop on the dm_ack cycle.
REQ-017 SHALL use the FSM states IDLE, LOAD_WAIT, DRAIN_WAIT. Transitions: any WAIT state returns to IDLE on dm_ack. At most one dm transaction is outstanding. dm outputs SHALL be stable while dm_req=1 and dm_ack=0.
REQ-018 SHALL give a presented load priority over draining when in IDLE. When sb_full=1, drain SHALL win.
REQ-019 SHALL compute in_ready = (state==IDLE) and not (store and sb_full) and not (REQ-014 stall).
REQ-020 SHALL update sb_count by +1 on enqueue, -1 on pop, and leave it unchanged when both occur in the same cycle. Pointers SHALL wrap modulo SB_DEPTH.
REQ-021 SHALL hold out_valid high for exactly one cycle per completed op. out_wreg, out_regwrite and out_map SHALL be those of that op.
REQ-022 SHALL ignore dm_ack when dm_req=0.

Reset
REQ-023 SHALL, when RESET=1 at a rising edge, set: state IDLE; buffer empty (sb_count=0, sb_empty=1, sb_full=0); all out_* = 0; dm_req=0, dm_we=0, dm_be=0; dm_addr=0, dm_wdata=0.
REQ-024 SHALL discard any in-flight transaction when reset occurs mid-operation; a late dm_ack SHALL be ignored.
REQ-025 SHALL keep in_ready=0 while RESET=1.

Verification
REQ-026 Bench SHALL check: SB 0x000000AB to 0x1001 -> entry be=0100, data 0x00AB0000. A following LBU 0x1001 SHALL forward 0x000000AB at N+1 with no dm_req.
REQ-027 Bench SHALL check: SB to 0x2000, then LW 0x2000 -> in_ready=0 until the entry drains (dm_we=1, be=1000). The LW SHALL then read memory.
REQ-028 Bench SHALL check: SB_DEPTH stores with dm_ack held 0 -> sb_full=1 and next store stalled. One ack SHALL give sb_count=SB_DEPTH-1 and accept the next store. The write pointer SHALL wrap to 0.
REQ-029 Bench SHALL check: LH 0x3002 with dm_rdata=0x1234F00D and 3-cycle ack delay -> out_wdata=0xFFFFF00D one edge after ack; dm_addr=0x3000 stable throughout.
REQ-030 Bench SHALL check: RESET asserted during DRAIN_WAIT with 2 entries -> next cycle sb_count=0, dm_req=0, out_valid=0. A subsequent dm_ack SHALL be ignored.
REQ-031 Bench SHALL check: ALU op (in_op=100000), in_addr=0xDEADBEEF, in_map=5 -> out_valid at N+1 with out_wdata=0xDEADBEEF and out_map=5.
